des3_key_sched_seq: RTL and testbench

//  Sequential, parametrised 3DES/DES round-key scheduler. Accepts up to three 64-bit keys and a mode, then streams
//  one 48-bit round key per cycle over a valid/ready port for all stages of the cipher (EDE order), with per-stage

---
 rtl/des3_key_sched_seq_if.sv | 27 ++
 rtl/des3_key_sched_seq.sv | 183 ++++++++++++++++++
 tb/tb_des3_key_sched_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/des3_key_sched_seq_if.sv
// rtl/des3_key_sched_seq_if.sv - key-set input and round-key stream bundle for the 3DES key scheduler
interface des3_key_sched_seq_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key1;
  logic [63:0] key2;
  logic [63:0] key3;
  logic [1:0]  mode;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_data;
  logic [3:0]  rk_round;
  logic [1:0]  rk_stage;
  logic        rk_last;
  logic        busy;
  logic        err;

  modport master (
    output key_valid, key1, key2, key3, mode, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_stage, rk_last, busy, err
  );

  modport slave (
    input  key_valid, key1, key2, key3, mode, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_stage, rk_last, busy, err
  );
endinterface

// File: rtl/des3_key_sched_seq.sv
// rtl/des3_key_sched_seq.sv - sequential DES/3DES round-key scheduler streaming one 48-bit key per handshake
module des3_key_sched_seq #(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_KEYS     = 3,
  parameter int PARITY_CHECK = 0
) (
  input logic                 clk,
  input logic                 n_rst,
  des3_key_sched_seq_if.slave bus
);
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [63:0] k1_q, k2_q, k3_q;
  logic        dec_q;
  logic [55:0] cd_q;
  logic [3:0]  round_q;
  logic [1:0]  stage_q;
  logic        rk_valid_q;
  logic        err_q;

  // cd[55:28] = C (C bit 1 at MSB), cd[27:0] = D
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(PC1_T[i] - 1)];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] rk;
    rk = '0;
    for (int j = 0; j < 48; j++) rk[6'(47 - j)] = cd[6'(56 - PC2_T[j])];
    return rk;
  endfunction

  function automatic logic [55:0] rol_cd(input logic [55:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  function automatic logic [55:0] ror_cd(input logic [55:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

  // Shift amount for 1-based round r is 2 except at rounds 1, 2, 9 and 16
  function automatic logic two_shift(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  // Encrypt order K1,K2,K3; decrypt order K3,K2,K1; single DES always K1
  function automatic logic [63:0] stage_key(input logic [1:0] s, input logic dec,
                                            input logic [63:0] k1, input logic [63:0] k2,
                                            input logic [63:0] k3);
    if (NUM_STAGES == 1) return k1;
    if (s == 2'd1) return k2;
    if ((s == 2'd0) ^ dec) return k1;
    return k3;
  endfunction

  // The middle stage of EDE runs opposite to the requested mode
  function automatic logic stage_dec(input logic [1:0] s, input logic dec);
    return dec ^ (NUM_STAGES == 3 && s == 2'd1);
  endfunction

  // Round 1 of a stage: decrypt starts at C0/D0 (equal to C16/D16), encrypt at C1/D1
  function automatic logic [55:0] load_cd(input logic [63:0] k, input logic dec);
    return dec ? pc1(k) : rol_cd(pc1(k), 1'b0);
  endfunction

  function automatic logic odd_bytes(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[b*8 +: 8]);
    return ok;
  endfunction

  logic [63:0] a1, a2, a3;
  logic        parity_ok;
  logic [1:0]  next_stage;
  logic [55:0] step_cd;

  // Keying-option aliasing, parity screen and the next C/D value within a stage
  always_comb begin
    a1 = bus.key1;
    a2 = (NUM_KEYS == 1) ? bus.key1 : bus.key2;
    a3 = (NUM_KEYS == 3) ? bus.key3 : bus.key1;
    parity_ok = (PARITY_CHECK == 0) ||
                (odd_bytes(bus.key1) &&
                 (NUM_STAGES == 1 || NUM_KEYS == 1 || odd_bytes(bus.key2)) &&
                 (NUM_STAGES == 1 || NUM_KEYS != 3 || odd_bytes(bus.key3)));
    next_stage = stage_q + 2'd1;
    if (stage_dec(stage_q, dec_q)) step_cd = ror_cd(cd_q, two_shift(5'd16 - {1'b0, round_q}));
    else                           step_cd = rol_cd(cd_q, two_shift({1'b0, round_q} + 5'd2));
  end

  // Control FSM: accept/reject key sets, advance rounds and stages on each handshake
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= IDLE;
      k1_q       <= '0;
      k2_q       <= '0;
      k3_q       <= '0;
      dec_q      <= 1'b0;
      cd_q       <= '0;
      round_q    <= '0;
      stage_q    <= '0;
      rk_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.key_valid) begin
            if (!bus.mode[1] && parity_ok) begin
              state_q    <= RUN;
              k1_q       <= a1;
              k2_q       <= a2;
              k3_q       <= a3;
              dec_q      <= bus.mode[0];
              cd_q       <= load_cd(stage_key(2'd0, bus.mode[0], a1, a2, a3),
                                    stage_dec(2'd0, bus.mode[0]));
              round_q    <= '0;
              stage_q    <= '0;
              rk_valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.rk_ready) begin
            if (round_q == 4'd15) begin
              round_q <= '0;
              if (stage_q == LAST_STAGE) begin
                state_q    <= IDLE;
                stage_q    <= '0;
                rk_valid_q <= 1'b0;
              end else begin
                stage_q <= next_stage;
                cd_q    <= load_cd(stage_key(next_stage, dec_q, k1_q, k2_q, k3_q),
                                   stage_dec(next_stage, dec_q));
              end
            end else begin
              round_q <= round_q + 4'd1;
              cd_q    <= step_cd;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream outputs are forced to zero whenever no key is being presented
  always_comb begin
    bus.key_ready = !n_rst && (state_q == IDLE);
    bus.rk_valid  = rk_valid_q;
    bus.rk_data   = rk_valid_q ? pc2(cd_q) : 48'd0;
    bus.rk_round  = rk_valid_q ? round_q : 4'd0;
    bus.rk_stage  = rk_valid_q ? stage_q : 2'd0;
    bus.rk_last   = rk_valid_q && (round_q == 4'd15) && (stage_q == LAST_STAGE);
    bus.busy      = (state_q == RUN);
    bus.err       = err_q;
  end
endmodule

// File: tb/tb_des3_key_sched_seq.sv
// tb/tb_des3_key_sched_seq.sv - self-checking bench for des3_key_sched_seq (single DES and 3DES instances)
module tb_des3_key_sched_seq;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  des3_key_sched_seq_if ia();
  des3_key_sched_seq_if ib();

  des3_key_sched_seq #(.NUM_STAGES(1), .NUM_KEYS(3), .PARITY_CHECK(0)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ia.slave));
  des3_key_sched_seq #(.NUM_STAGES(3), .NUM_KEYS(3), .PARITY_CHECK(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ib.slave));

  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic        key_ready;
    logic        rk_valid;
    logic [47:0] data;
    logic [3:0]  round;
    logic [1:0]  stage;
    logic        last;
    logic        busy;
    logic        err;
  } obs_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [54:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel) o = '{ib.key_ready, ib.rk_valid, ib.rk_data, ib.rk_round, ib.rk_stage, ib.rk_last, ib.busy, ib.err};
    else     o = '{ia.key_ready, ia.rk_valid, ia.rk_data, ia.rk_round, ia.rk_stage, ia.rk_last, ia.busy, ia.err};
    return o;
  endfunction

  task automatic drive(input bit sel, input logic kv, input logic [63:0] k1, input logic [63:0] k2,
                       input logic [63:0] k3, input logic [1:0] md, input logic rdy);
    if (sel) begin
      ib.key_valid = kv; ib.key1 = k1; ib.key2 = k2; ib.key3 = k3; ib.mode = md; ib.rk_ready = rdy;
    end else begin
      ia.key_valid = kv; ia.key1 = k1; ia.key2 = k2; ia.key3 = k3; ia.mode = md; ia.rk_ready = rdy;
    end
  endtask

  // Round key after a cumulative left rotation of C0/D0 by 'total' positions
  function automatic logic [47:0] ref_rk(input logic [63:0] key, input int total);
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    logic [47:0] rk;
    int t;
    for (int i = 0; i < 28; i++) begin
      c0[5'(27 - i)] = key[6'(PC1_T[i] - 1)];
      d0[5'(27 - i)] = key[6'(PC1_T[i + 28] - 1)];
    end
    t = total % 28;
    c = (c0 << t) | (c0 >> (28 - t));
    d = (d0 << t) | (d0 >> (28 - t));
    cd = {c, d};
    for (int j = 0; j < 48; j++) rk[6'(47 - j)] = cd[6'(56 - PC2_T[j])];
    return rk;
  endfunction

  // Expected stream: per stage the 16 encryption keys of the chosen key, reversed for decrypt stages
  task automatic build_expected(input int ns, input logic [63:0] k1, input logic [63:0] k2,
                                input logic [63:0] k3, input logic [1:0] md);
    logic [63:0] kk [3];
    int order [3];
    logic [47:0] enc [16];
    logic [63:0] key;
    logic dec;
    int total;
    kk[0] = k1; kk[1] = k2; kk[2] = k3;
    if (md[0]) order = '{2, 1, 0}; else order = '{0, 1, 2};
    exp_q.delete();
    for (int s = 0; s < ns; s++) begin
      key = (ns == 1) ? k1 : kk[order[s]];
      dec = md[0] ^ (ns == 3 && s == 1);
      total = 0;
      for (int r = 0; r < 16; r++) begin
        total += SH[r];
        enc[r] = ref_rk(key, total);
      end
      for (int r = 0; r < 16; r++)
        exp_q.push_back({dec ? enc[15 - r] : enc[r], 4'(r), 2'(s), 1'(s == ns - 1 && r == 15)});
    end
  endtask

  function automatic logic [63:0] rand_key();
    logic [63:0] k;
    k = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) k[b*8] = ~(^k[b*8+1 +: 7]);
    return k;
  endfunction

  task automatic run_set(input bit sel, input logic [63:0] k1, input logic [63:0] k2,
                         input logic [63:0] k3, input logic [1:0] md, input bit rnd,
                         output logic [47:0] first_rk, output logic [47:0] last_rk);
    obs_t o, prev;
    int ns, cyc, total;
    logic rdy;
    bit stalled, got_first;
    ns = sel ? 3 : 1;
    build_expected(ns, k1, k2, k3, md);
    total = exp_q.size();
    first_rk = '0; last_rk = '0; got_first = 0;
    @(negedge clk);
    o = get_obs(sel);
    chk("key_ready_idle", 64'(o.key_ready), 64'd1);
    drive(sel, 1'b1, k1, k2, k3, md, 1'b0);
    @(negedge clk);
    o = get_obs(sel);
    chk("accept_latency", 64'({o.rk_valid, o.busy}), 64'b11);
    prev = o; stalled = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      o = get_obs(sel);
      chk("valid_no_gap", 64'(o.rk_valid), 64'd1);
      if (stalled) chk("stall_hold", 64'({o.data, o.round, o.stage, o.last}),
                       64'({prev.data, prev.round, prev.stage, prev.last}));
      if (o.rk_valid) chk("rk_key", 64'({o.data, o.round, o.stage, o.last}), 64'(exp_q[0]));
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      // Keep offering a different key set while busy; it must be ignored
      drive(sel, exp_q.size() > 1, ~k1, ~k2, ~k3, 2'b00, rdy);
      if (o.rk_valid && rdy) begin
        if (!got_first) begin first_rk = o.data; got_first = 1; end
        last_rk = o.data;
        void'(exp_q.pop_front());
        stalled = 0;
      end else begin
        stalled = o.rk_valid;
      end
      prev = o;
      @(negedge clk);
      cyc++;
    end
    drive(sel, 1'b0, '0, '0, '0, 2'b00, 1'b0);
    chk("stream_complete", 64'(exp_q.size()), 64'd0);
    if (!rnd) chk("valid_cycle_count", 64'(cyc), 64'(total));
    o = get_obs(sel);
    chk("idle_after_last", 64'(o), 64'(obs_t'{1'b1, 1'b0, 48'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}));
  endtask

  task automatic reject_test(input bit sel, input string tag, input logic [63:0] k1,
                             input logic [63:0] k2, input logic [63:0] k3, input logic [1:0] md);
    obs_t o;
    @(negedge clk);
    drive(sel, 1'b1, k1, k2, k3, md, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    o = get_obs(sel);
    chk({tag, "_err_pulse"}, 64'({o.err, o.rk_valid, o.key_ready, o.busy}), 64'b1010);
    @(negedge clk);
    o = get_obs(sel);
    chk({tag, "_err_clear"}, 64'({o.err, o.rk_valid, o.key_ready, o.busy}), 64'b0010);
  endtask

  logic [47:0] f_rk, l_rk, f2, l2;
  logic [63:0] ka, kb, kc;
  obs_t o;
  bit found;

  initial begin
    n_rst = 1'b1;
    drive(0, 1'b0, '0, '0, '0, 2'b00, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", 64'(get_obs(0)), 64'd0);
    chk("reset_b", 64'(get_obs(1)), 64'd0);
    n_rst = 1'b0;

    // FIPS worked example, single DES
    run_set(0, 64'h8FFB3DD99EEA2CC8, '0, '0, 2'b00, 0, f_rk, l_rk);
    chk("fips_enc_first", 64'(f_rk), 64'h1B02EFFC7072);
    chk("fips_enc_16th", 64'(l_rk), 64'hCB3D8B0E17F5);
    run_set(0, 64'h8FFB3DD99EEA2CC8, '0, '0, 2'b01, 0, f_rk, l_rk);
    chk("fips_dec_first", 64'(f_rk), 64'hCB3D8B0E17F5);
    chk("fips_dec_16th", 64'(l_rk), 64'h1B02EFFC7072);
    run_set(0, rand_key(), '0, '0, 2'b01, 1, f_rk, l_rk);
    run_set(0, {$urandom, $urandom}, '0, '0, 2'b00, 1, f_rk, l_rk);

    // 3DES EDE, both directions, full and random back-pressure
    for (int i = 0; i < 4; i++) begin
      ka = rand_key(); kb = rand_key(); kc = rand_key();
      run_set(1, ka, kb, kc, 2'(i % 2), i >= 2, f_rk, l_rk);
    end

    // Rejections: invalid mode and single-bit parity error
    reject_test(1, "b_mode10", rand_key(), rand_key(), rand_key(), 2'b10);
    reject_test(1, "b_mode11", rand_key(), rand_key(), rand_key(), 2'b11);
    ka = rand_key();
    reject_test(1, "b_parity", rand_key(), ka ^ (64'd1 << $urandom_range(0, 63)), rand_key(), 2'b00);
    reject_test(0, "a_mode11", rand_key(), '0, '0, 2'b11);

    // Reset in the middle of stage 1, then a clean set
    ka = rand_key(); kb = rand_key(); kc = rand_key();
    @(negedge clk);
    drive(1, 1'b1, ka, kb, kc, 2'b00, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      o = get_obs(1);
      if (o.rk_valid && o.stage == 2'd1 && o.round == 4'd7) found = 1;
      else @(negedge clk);
    end
    chk("reached_stage1_round7", 64'(found), 64'd1);
    n_rst = 1'b1;
    @(negedge clk);
    chk("midstream_reset", 64'(get_obs(1)), 64'd0);
    n_rst = 1'b0;
    drive(1, 1'b0, '0, '0, '0, 2'b00, 1'b0);
    run_set(1, ka, kb, kc, 2'b01, 0, f_rk, l_rk);
    run_set(1, ka, kb, kc, 2'b00, 1, f2, l2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
